sobolrng_mdim: RTL and testbench
================================

SOBOLRNG_MDIM -- requirements
Module: sobolrng_mdim

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 8, giving the sample width in bits; legal range 2-16.
REQ-002 The block SHALL have parameter NDIM, default 4, giving the number of independent Sobol dimensions; legal range 1-8.
REQ-003 The block SHALL have port iClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port iRstN, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port iEn, input, 1 bit: advance the sequence by one index.
REQ-006 The block SHALL have port iClr, input, 1 bit: synchronous restart of the sequence to index 0.
REQ-007 The block SHALL have port iCfgWe, input, 1 bit: direction-vector write strobe.
REQ-008 The block SHALL have port iCfgDim, input, 3 bits: target dimension of the write.
REQ-009 The block SHALL have port iCfgIdx, input, 4 bits: target vector index k of the write.
REQ-010 The block SHALL have port iCfgData, input, BITWIDTH bits: write data.
REQ-011 The block SHALL have port oRand, output, NDIM*BITWIDTH bits: packed samples, dimension d at bits [d*BITWIDTH +: BITWIDTH].
REQ-012 The block SHALL have port oCnt, output, BITWIDTH bits: current sequence index n.
REQ-013 The block SHALL have port oWrap, output, 1 bit: one-cycle pulse marking the completion of a full period.

Function
REQ-014 The block SHALL hold one shared index counter n and one BITWIDTH-bit output register per dimension; all outputs are registered.
REQ-015 The block SHALL, on a cycle with iEn=1, iClr=0 and n != 2^BITWIDTH-1, compute j = position of the least-significant zero bit of n, XOR each dimension's register with that dimension's vector v[d][j], and increment n; results are visible the cycle after iEn is sampled.
REQ-016 The block SHALL, on a cycle with iEn=1, iClr=0 and n = 2^BITWIDTH-1, load n=0, clear all output registers to 0 and assert oWrap for exactly that next cycle.
REQ-017 The block SHALL leave n, oRand and oWrap=0 unchanged on a cycle with iEn=0 and iClr=0.
REQ-018 The block SHALL, on a cycle with iClr=1, set n=0 and all output registers to 0, with oWrap=0, regardless of iEn; iClr has priority over iEn.
REQ-019 Dimension 0 SHALL use fixed vectors v[0][k] = 2^(BITWIDTH-1-k) for k=0..BITWIDTH-1; writes to dimension 0 SHALL be ignored.
REQ-020 Dimensions 1..NDIM-1 SHALL hold writable vector tables of BITWIDTH entries each, reset to the dimension-0 values.
REQ-021 The block SHALL, on a cycle with iCfgWe=1, write iCfgData into v[iCfgDim][iCfgIdx]; writes with iCfgDim>=NDIM or iCfgIdx>=BITWIDTH SHALL be ignored without side effect.
REQ-022 The block SHALL, when a write and a step occur in the same cycle, compute the step with the pre-write vector; the new value applies from the following step onward.
REQ-023 Vector writes SHALL NOT alter n or oRand.

Reset
REQ-024 The block SHALL, while iRstN=0 and independent of iClk, set n=0, oRand=0 and oWrap=0, and restore all vector tables to the REQ-020 defaults.
REQ-025 The block SHALL, on reset asserted mid-sequence, resume from index 0 on the first iEn after release, with no residue from prior state.

Verification
REQ-026 BITWIDTH=4, NDIM=1, iEn held high from reset release -> oRand on successive cycles 0,8,12,4,6,14,10,2,3,11,15,7,5,13,9,1, then 0 with oWrap=1 for one cycle.
REQ-027 BITWIDTH=4: write v[1][0..3] = 8,12,10,15, then iEn held high -> dimension 1 reads 0,8,4,12,6,14,2,10 over the first eight cycles; dimension 0 is unchanged from REQ-026.
REQ-028 iEn toggled 1,0,1,0 -> oRand and oCnt advance only after high cycles; oCnt reads 1,1,2,2.
REQ-029 iClr=1 together with iEn=1 at n=5 -> next cycle n=0, oRand=0, oWrap=0; the next iEn gives dimension 0 = 8.
REQ-030 Write to dimension 0, and to iCfgDim=NDIM, during a run -> sequences bit-identical to a run without the writes.
REQ-031 iRstN pulsed low asynchronously between clock edges at n=9 -> outputs are 0 immediately, vector tables return to defaults, and the REQ-026 sequence restarts on release.

Source files
------------

// File: rtl/sobolrng_mdim_if.sv
// Bundle of the sobolrng_mdim control, config-write and result signals.
// master drives step/clear/config and reads results; slave is the generator side.
interface sobolrng_mdim_if #(
  parameter int BITWIDTH = 8,
  parameter int NDIM     = 4
);
  logic                     en;
  logic                     clr;
  logic                     cfg_we;
  logic [2:0]               cfg_dim;
  logic [3:0]               cfg_idx;
  logic [BITWIDTH-1:0]      cfg_data;
  logic [NDIM*BITWIDTH-1:0] rnd;
  logic [BITWIDTH-1:0]      cnt;
  logic                     wrap;

  modport master (
    output en, clr, cfg_we, cfg_dim, cfg_idx, cfg_data,
    input  rnd, cnt, wrap
  );

  modport slave (
    input  en, clr, cfg_we, cfg_dim, cfg_idx, cfg_data,
    output rnd, cnt, wrap
  );
endinterface

// File: rtl/sobolrng_mdim.sv
// Multi-dimensional Sobol sequence generator (Gray-code XOR form).
// iEn steps, iClr restarts, iCfg* writes direction vectors; oRand/oCnt/oWrap registered.
module sobolrng_mdim #(
  parameter int BITWIDTH = 8,
  parameter int NDIM     = 4
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iEn,
  input  logic                     iClr,
  input  logic                     iCfgWe,
  input  logic [2:0]               iCfgDim,
  input  logic [3:0]               iCfgIdx,
  input  logic [BITWIDTH-1:0]      iCfgData,
  output logic [NDIM*BITWIDTH-1:0] oRand,
  output logic [BITWIDTH-1:0]      oCnt,
  output logic                     oWrap
);

  localparam int BW = BITWIDTH;
  localparam int IW = $clog2(BW);

  typedef logic [BW-1:0] word_t;

  function automatic word_t dflt(input int k);
    return word_t'(1) << (BW - 1 - k);
  endfunction

  word_t         cnt_q, cnt_d;
  logic          wrap_q, wrap_d;
  word_t         rnd_q [NDIM];
  word_t         rnd_d [NDIM];
  word_t         vec_q [NDIM][BW];
  word_t         vec_d [NDIM][BW];
  logic [IW-1:0] lsz;
  logic          last;

  // Lowest zero bit of n selects the vector; scan downward so it wins.
  always_comb begin
    lsz = '0;
    for (int i = BW - 1; i >= 0; i--) begin
      if (!cnt_q[i]) lsz = IW'(i);
    end
  end

  assign last = &cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    rnd_d  = rnd_q;
    wrap_d = 1'b0;
    if (iClr) begin
      cnt_d = '0;
      for (int d = 0; d < NDIM; d++) rnd_d[d] = '0;
    end else if (iEn) begin
      if (last) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
        for (int d = 0; d < NDIM; d++) rnd_d[d] = '0;
      end else begin
        cnt_d = cnt_q + word_t'(1);
        for (int d = 0; d < NDIM; d++) begin
          rnd_d[d] = rnd_q[d] ^ vec_q[d][lsz];
        end
      end
    end
  end

  // Dimension 0 is never written, so its table stays at the defaults.
  // Out-of-range dim/idx simply match no entry.
  always_comb begin
    vec_d = vec_q;
    for (int d = 1; d < NDIM; d++) begin
      for (int k = 0; k < BW; k++) begin
        if (iCfgWe && iCfgDim == 3'(d) && iCfgIdx == 4'(k)) begin
          vec_d[d][k] = iCfgData;
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      for (int d = 0; d < NDIM; d++) begin
        rnd_q[d] <= '0;
        for (int k = 0; k < BW; k++) vec_q[d][k] <= dflt(k);
      end
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      rnd_q  <= rnd_d;
      vec_q  <= vec_d;
    end
  end

  for (genvar g = 0; g < NDIM; g++) begin : g_out
    assign oRand[g*BW +: BW] = rnd_q[g];
  end

  assign oCnt  = cnt_q;
  assign oWrap = wrap_q;

endmodule

// File: tb/tb_sobolrng_mdim.sv
// Directed bench for sobolrng_mdim at BITWIDTH=4, NDIM=2.
// Expected sequences are hand-derived constant tables.
module tb_sobolrng_mdim;

  localparam int BW = 4;
  localparam int ND = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sobolrng_mdim_if #(.BITWIDTH(BW), .NDIM(ND)) bus ();

  sobolrng_mdim #(.BITWIDTH(BW), .NDIM(ND)) dut (
    .iClk    (clk),
    .iRstN   (rst_n),
    .iEn     (bus.en),
    .iClr    (bus.clr),
    .iCfgWe  (bus.cfg_we),
    .iCfgDim (bus.cfg_dim),
    .iCfgIdx (bus.cfg_idx),
    .iCfgData(bus.cfg_data),
    .oRand   (bus.rnd),
    .oCnt    (bus.cnt),
    .oWrap   (bus.wrap)
  );

  int n_vec = 0;
  int n_err = 0;

  int exp0 [16] = '{8, 12, 4, 6, 14, 10, 2, 3,
                    11, 15, 7, 5, 13, 9, 1, 0};
  int exp1a [7] = '{8, 4, 12, 6, 14, 2, 10};
  int exp1c [8] = '{3, 15, 12, 6, 5, 9, 10, 5};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
  endtask

  task automatic cfg(input int d, input int i, input int v);
    bus.cfg_we   = 1'b1;
    bus.cfg_dim  = 3'(d);
    bus.cfg_idx  = 4'(i);
    bus.cfg_data = 4'(v);
    step();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic run_full(input string tag);
    for (int i = 0; i < 16; i++) begin
      step();
      chk({tag, "_d0"}, 32'(bus.rnd[3:0]), 32'(exp0[i]));
      chk({tag, "_d1"}, 32'(bus.rnd[7:4]), 32'(exp0[i]));
      chk({tag, "_cnt"}, 32'(bus.cnt), 32'((i + 1) % 16));
      chk({tag, "_wrap"}, 32'(bus.wrap), (i == 15) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.clr = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_dim = '0;
    bus.cfg_idx = '0;
    bus.cfg_data = '0;

    #3;
    chk("rst_rand", 32'(bus.rnd), 32'd0);
    chk("rst_cnt", 32'(bus.cnt), 32'd0);
    chk("rst_wrap", 32'(bus.wrap), 32'd0);

    // full period from reset release
    #19;
    rst_n = 1'b1;
    bus.en = 1'b1;
    #1;
    chk("rel_rand", 32'(bus.rnd), 32'd0);
    run_full("per");
    step();
    chk("per2_d0", 32'(bus.rnd[3:0]), 32'd8);
    chk("per2_wrap", 32'(bus.wrap), 32'd0);
    bus.en = 1'b0;
    step();
    chk("hold_d0", 32'(bus.rnd[3:0]), 32'd8);
    chk("hold_cnt", 32'(bus.cnt), 32'd1);

    // programmed dimension 1
    do_clr();
    cfg(1, 0, 8);
    cfg(1, 1, 12);
    cfg(1, 2, 10);
    cfg(1, 3, 15);
    chk("cfg_cnt", 32'(bus.cnt), 32'd0);
    chk("cfg_rand", 32'(bus.rnd), 32'd0);
    bus.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("dim1_d1", 32'(bus.rnd[7:4]), 32'(exp1a[i]));
      chk("dim1_d0", 32'(bus.rnd[3:0]), 32'(exp0[i]));
    end
    bus.en = 1'b0;

    // enable toggling
    do_clr();
    for (int i = 0; i < 4; i++) begin
      bus.en = (i % 2 == 0);
      step();
      chk("tog_cnt", 32'(bus.cnt), 32'(i / 2 + 1));
      chk("tog_d0", 32'(bus.rnd[3:0]), 32'(exp0[i / 2]));
    end

    // clear beats enable
    do_clr();
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pre_clr_cnt", 32'(bus.cnt), 32'd5);
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    chk("clr_cnt", 32'(bus.cnt), 32'd0);
    chk("clr_rand", 32'(bus.rnd), 32'd0);
    chk("clr_wrap", 32'(bus.wrap), 32'd0);
    step();
    chk("post_clr_d0", 32'(bus.rnd[3:0]), 32'd8);
    bus.en = 1'b0;

    // write and step in the same cycle: old vector used
    do_clr();
    bus.en = 1'b1;
    cfg(1, 0, 3);
    chk("wr_step_d1a", 32'(bus.rnd[7:4]), 32'd8);
    step();
    chk("wr_step_d1b", 32'(bus.rnd[7:4]), 32'd4);
    step();
    chk("wr_step_d1c", 32'(bus.rnd[7:4]), 32'd7);
    bus.en = 1'b0;

    // ignored writes during a run
    do_clr();
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cfg_we = 1'b1;
      case (i % 3)
        0: begin
          bus.cfg_dim = 3'd0;
          bus.cfg_idx = 4'(i % 4);
        end
        1: begin
          bus.cfg_dim = 3'(ND + i % 2);
          bus.cfg_idx = 4'(i % 4);
        end
        default: begin
          bus.cfg_dim = 3'd1;
          bus.cfg_idx = 4'(BW + i);
        end
      endcase
      bus.cfg_data = 4'd5;
      step();
      chk("ign_d0", 32'(bus.rnd[3:0]), 32'(exp0[i]));
      chk("ign_d1", 32'(bus.rnd[7:4]), 32'(exp1c[i]));
    end
    bus.cfg_we = 1'b0;
    bus.en = 1'b0;

    // asynchronous reset mid-sequence
    do_clr();
    bus.en = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("pre_rst_cnt", 32'(bus.cnt), 32'd9);
    bus.en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rand", 32'(bus.rnd), 32'd0);
    chk("arst_cnt", 32'(bus.cnt), 32'd0);
    chk("arst_wrap", 32'(bus.wrap), 32'd0);
    #2;
    rst_n = 1'b1;
    bus.en = 1'b1;
    run_full("rerun");
    bus.en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
